// File: rtl/clint_arb.sv
// Core-local interrupt arbiter: ECALL/EBREAK/MRET plus NUM_IRQ prioritised level irqs.
// Optional vectored mtvec mode is compiled in with CLINT_VECTORED_EN.
module clint_arb #(
    parameter int NUM_IRQ        = 8,
    parameter int XLEN           = 32,
    parameter int IRQ_CAUSE_BASE = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_IRQ-1:0]  irq_i,
    input  logic [NUM_IRQ-1:0]  mie_i,
    input  logic                inst_valid_i,
    input  logic [31:0]         inst_i,
    input  logic [XLEN-1:0]     inst_addr_i,
    input  logic [XLEN-1:0]     mtvec_i,
    input  logic [XLEN-1:0]     mepc_i,
    input  logic [XLEN-1:0]     mstatus_i,
    output logic                hold_o,
    output logic                csr_we_o,
    output logic [11:0]         csr_waddr_o,
    output logic [XLEN-1:0]     csr_wdata_o,
    output logic                int_assert_o,
    output logic [XLEN-1:0]     int_addr_o,
    output logic [NUM_IRQ-1:0]  irq_ack_o
);

    localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    typedef enum logic [2:0] {
        IDLE,
        MEPC,
        MCAUSE,
        MSTATUS,
        MRET,
        ASSERT
    } state_t;

    state_t              state, state_n;
    logic [XLEN-1:0]     pc_q;
    logic [XLEN-1:0]     cause_q, cause_n;
    logic [IW-1:0]       idx_q, idx_n;
    logic                async_q, async_n;
    logic                mret_q, mret_n;

    logic [NUM_IRQ-1:0]  pend;
    logic [IW-1:0]       k_sel;
    logic                is_ecall, is_ebreak, is_mret, irq_take;
    logic                entry;

    logic [XLEN-1:0]     trap_status, mret_status;
    logic [XLEN-1:0]     base, trap_addr;

    // Lowest pending index wins
    always_comb begin
        pend  = irq_i & mie_i;
        k_sel = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) k_sel = IW'(i);
        end
    end

    assign is_ecall  = inst_i == INST_ECALL;
    assign is_ebreak = inst_i == INST_EBREAK;
    assign is_mret   = inst_i == INST_MRET;
    assign irq_take  = (|pend) && mstatus_i[3];

    assign entry = (state == IDLE) && inst_valid_i &&
                   (is_ecall || is_ebreak || irq_take || is_mret);

    always_comb begin
        state_n = state;
        cause_n = '0;
        idx_n   = '0;
        async_n = 1'b0;
        mret_n  = 1'b0;
        case (state)
            IDLE: begin
                if (inst_valid_i) begin
                    if (is_ecall) begin
                        state_n = MEPC;
                        cause_n = XLEN'(11);
                    end else if (is_ebreak) begin
                        state_n = MEPC;
                        cause_n = XLEN'(3);
                    end else if (irq_take) begin
                        state_n = MEPC;
                        cause_n = XLEN'(IRQ_CAUSE_BASE) + XLEN'(k_sel);
                        cause_n[XLEN-1] = 1'b1;
                        idx_n   = k_sel;
                        async_n = 1'b1;
                    end else if (is_mret) begin
                        state_n = MRET;
                        mret_n  = 1'b1;
                    end
                end
            end
            MEPC:    state_n = MCAUSE;
            MCAUSE:  state_n = MSTATUS;
            MSTATUS: state_n = ASSERT;
            MRET:    state_n = ASSERT;
            ASSERT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc_q    <= '0;
            cause_q <= '0;
            idx_q   <= '0;
            async_q <= 1'b0;
            mret_q  <= 1'b0;
        end else begin
            state <= state_n;
            if (entry) begin
                pc_q    <= inst_addr_i;
                cause_q <= cause_n;
                idx_q   <= idx_n;
                async_q <= async_n;
                mret_q  <= mret_n;
            end
        end
    end

    always_comb begin
        trap_status        = mstatus_i;
        trap_status[7]     = mstatus_i[3];
        trap_status[3]     = 1'b0;
        trap_status[12:11] = 2'b11;
        mret_status        = mstatus_i;
        mret_status[3]     = mstatus_i[7];
        mret_status[7]     = 1'b1;
    end

    assign base = mtvec_i & ~XLEN'(3);

`ifdef CLINT_VECTORED_EN
    always_comb begin
        trap_addr = base;
        if (async_q && mtvec_i[1:0] == 2'b01)
            trap_addr = base + ((XLEN'(IRQ_CAUSE_BASE) + XLEN'(idx_q)) << 2);
    end
`else
    assign trap_addr = base;
`endif

    always_comb begin
        hold_o       = 1'b0;
        csr_we_o     = 1'b0;
        csr_waddr_o  = '0;
        csr_wdata_o  = '0;
        int_assert_o = 1'b0;
        int_addr_o   = '0;
        irq_ack_o    = '0;
        if (!rst) begin
            hold_o = (state != IDLE) || entry;
            case (state)
                MEPC: begin
                    csr_we_o    = 1'b1;
                    csr_waddr_o = CSR_MEPC;
                    csr_wdata_o = pc_q;
                end
                MCAUSE: begin
                    csr_we_o    = 1'b1;
                    csr_waddr_o = CSR_MCAUSE;
                    csr_wdata_o = cause_q;
                end
                MSTATUS: begin
                    csr_we_o    = 1'b1;
                    csr_waddr_o = CSR_MSTATUS;
                    csr_wdata_o = trap_status;
                end
                MRET: begin
                    csr_we_o    = 1'b1;
                    csr_waddr_o = CSR_MSTATUS;
                    csr_wdata_o = mret_status;
                end
                ASSERT: begin
                    int_assert_o = 1'b1;
                    int_addr_o   = mret_q ? mepc_i : trap_addr;
                    if (async_q)
                        irq_ack_o = NUM_IRQ'(1) << idx_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clint_arb.sv
// Cycle-by-cycle vector bench for clint_arb; expected values hand-computed.
// Vectored-mode expectation follows CLINT_VECTORED_EN.
module tb_clint_arb;

    localparam int N = 8;
    localparam int X = 32;

    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] MEPC   = 32'h0000_0104;

`ifdef CLINT_VECTORED_EN
    localparam logic [31:0] VEC_ADDR = 32'h240;
`else
    localparam logic [31:0] VEC_ADDR = 32'h200;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  irq, mie, ack;
    logic          vld;
    logic [31:0]   inst;
    logic [X-1:0]  pc, mtvec, mepc, mstatus;
    logic          hold, we, ast;
    logic [11:0]   waddr;
    logic [X-1:0]  wdata, addr;

    always #5 clk = ~clk;

    clint_arb #(.NUM_IRQ(N), .XLEN(X), .IRQ_CAUSE_BASE(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .irq_i        (irq),
        .mie_i        (mie),
        .inst_valid_i (vld),
        .inst_i       (inst),
        .inst_addr_i  (pc),
        .mtvec_i      (mtvec),
        .mepc_i       (mepc),
        .mstatus_i    (mstatus),
        .hold_o       (hold),
        .csr_we_o     (we),
        .csr_waddr_o  (waddr),
        .csr_wdata_o  (wdata),
        .int_assert_o (ast),
        .int_addr_o   (addr),
        .irq_ack_o    (ack)
    );

    typedef struct {
        logic          rst;
        logic          vld;
        logic [31:0]   inst;
        logic [31:0]   pc;
        logic [N-1:0]  irq;
        logic [N-1:0]  mie;
        logic [31:0]   ms;
        logic [31:0]   mtv;
        logic          hold;
        logic          we;
        logic [11:0]   wa;
        logic [31:0]   wd;
        logic          as;
        logic [31:0]   ad;
        logic [N-1:0]  ack;
    } vec_t;

    vec_t vecs[$];
    int   applied = 0;
    int   errors  = 0;

    function automatic void r(
        logic rs, logic v, logic [31:0] in, logic [31:0] p,
        logic [N-1:0] iq, logic [N-1:0] me, logic [31:0] ms, logic [31:0] mt,
        logic h, logic w, logic [11:0] wa, logic [31:0] wd,
        logic a, logic [31:0] ad, logic [N-1:0] ak);
        vec_t t;
        t.rst = rs; t.vld = v; t.inst = in; t.pc = p;
        t.irq = iq; t.mie = me; t.ms = ms; t.mtv = mt;
        t.hold = h; t.we = w; t.wa = wa; t.wd = wd;
        t.as = a; t.ad = ad; t.ack = ak;
        vecs.push_back(t);
    endfunction

    task automatic check(string name, logic h, logic w, logic [11:0] wa,
                         logic [31:0] wd, logic a, logic [31:0] ad,
                         logic [N-1:0] ak);
        applied++;
        if ({hold, we, waddr, wdata, ast, addr, ack} !==
            {h, w, wa, wd, a, ad, ak}) begin
            errors++;
            $display("FAIL %s: got hold=%b we=%b wa=%h wd=%h as=%b ad=%h ack=%h want hold=%b we=%b wa=%h wd=%h as=%b ad=%h ack=%h",
                     name, hold, we, waddr, wdata, ast, addr, ack,
                     h, w, wa, wd, a, ad, ak);
        end
    endtask

    task automatic drive(logic rs, logic v, logic [31:0] in, logic [31:0] p,
                         logic [N-1:0] iq, logic [N-1:0] me,
                         logic [31:0] ms, logic [31:0] mt);
        rst = rs; vld = v; inst = in; pc = p;
        irq = iq; mie = me; mstatus = ms; mtvec = mt;
    endtask

    initial begin
        mepc = MEPC;
        drive(1, 0, NOP, 0, 0, 0, 0, 32'h200);

        // reset: outputs stay 0 even with a trap presented
        r(1,1,ECALL ,'h0 ,0,0,'h8,'h200, 0,0,0,0,0,0,0);
        r(1,0,NOP   ,'h0 ,0,0,'h8,'h200, 0,0,0,0,0,0,0);
        // ECALL
        r(0,1,ECALL ,'h100,0,0,'h8,'h200, 1,0,0,0,0,0,0);
        r(0,0,NOP   ,'h0 ,0,0,'h8,'h200, 1,1,'h341,'h100,0,0,0);
        r(0,0,NOP   ,'h0 ,0,0,'h8,'h200, 1,1,'h342,'hB,0,0,0);
        r(0,0,NOP   ,'h0 ,0,0,'h8,'h200, 1,1,'h300,'h1880,0,0,0);
        r(0,0,NOP   ,'h0 ,0,0,'h8,'h200, 1,0,0,0,1,'h200,0);
        r(0,0,NOP   ,'h0 ,0,0,'h8,'h200, 0,0,0,0,0,0,0);
        // priority + source dropping after latch
        r(0,1,NOP   ,'h40,'h24,'h20,'h8,'h200, 1,0,0,0,0,0,0);
        r(0,1,NOP   ,'h44,'h24,'h20,'h8,'h200, 1,1,'h341,'h40,0,0,0);
        r(0,1,NOP   ,'h48,'h00,'h20,'h8,'h200, 1,1,'h342,'h80000015,0,0,0);
        r(0,0,NOP   ,'h0 ,'h00,'h20,'h8,'h200, 1,1,'h300,'h1880,0,0,0);
        r(0,0,NOP   ,'h0 ,'h00,'h20,'h8,'h200, 1,0,0,0,1,'h200,'h20);
        r(0,1,NOP   ,'h4c,'h00,'h20,'h8,'h200, 0,0,0,0,0,0,0);
        // masking
        r(0,1,NOP   ,'h80,'h01,'h00,'h8,'h200, 0,0,0,0,0,0,0);
        r(0,1,NOP   ,'h80,'h01,'h01,'h0,'h200, 0,0,0,0,0,0,0);
        r(0,0,NOP   ,'h80,'h01,'h01,'h8,'h200, 0,0,0,0,0,0,0);
        r(0,1,NOP   ,'h80,'h01,'h01,'h8,'h200, 1,0,0,0,0,0,0);
        r(0,1,NOP   ,'h84,'h01,'h01,'h8,'h200, 1,1,'h341,'h80,0,0,0);
        r(0,1,NOP   ,'h88,'h01,'h01,'h8,'h200, 1,1,'h342,'h80000010,0,0,0);
        r(0,1,NOP   ,'h8c,'h01,'h01,'h8,'h200, 1,1,'h300,'h1880,0,0,0);
        r(0,1,NOP   ,'h90,'h01,'h01,'h8,'h200, 1,0,0,0,1,'h200,'h01);
        r(0,0,NOP   ,'h0 ,'h00,'h01,'h8,'h200, 0,0,0,0,0,0,0);
        // MRET
        r(0,1,MRET  ,'h300,0,0,'h1880,'h200, 1,0,0,0,0,0,0);
        r(0,0,NOP   ,'h0 ,0,0,'h1880,'h200, 1,1,'h300,'h1888,0,0,0);
        r(0,0,NOP   ,'h0 ,0,0,'h1888,'h200, 1,0,0,0,1,'h104,0);
        r(0,0,NOP   ,'h0 ,0,0,'h1888,'h200, 0,0,0,0,0,0,0);
        // ECALL with irq pending: ECALL first
        r(0,1,ECALL ,'h10,'h01,'h01,'h8,'h200, 1,0,0,0,0,0,0);
        r(0,0,NOP   ,'h0 ,'h01,'h01,'h8,'h200, 1,1,'h341,'h10,0,0,0);
        r(0,0,NOP   ,'h0 ,'h01,'h01,'h8,'h200, 1,1,'h342,'hB,0,0,0);
        r(0,0,NOP   ,'h0 ,'h01,'h01,'h8,'h200, 1,1,'h300,'h1880,0,0,0);
        r(0,0,NOP   ,'h0 ,'h01,'h01,'h8,'h200, 1,0,0,0,1,'h200,0);
        r(0,1,NOP   ,'h14,'h01,'h01,'h1880,'h200, 0,0,0,0,0,0,0);
        // re-enabled irq, then rst at T+2
        r(0,1,NOP   ,'h20,'h01,'h01,'h8,'h200, 1,0,0,0,0,0,0);
        r(0,0,NOP   ,'h0 ,'h01,'h01,'h8,'h200, 1,1,'h341,'h20,0,0,0);
        r(1,0,NOP   ,'h0 ,'h00,'h01,'h8,'h200, 0,0,0,0,0,0,0);
        r(0,0,NOP   ,'h0 ,'h00,'h01,'h8,'h200, 0,0,0,0,0,0,0);
        r(0,0,NOP   ,'h0 ,'h00,'h01,'h8,'h200, 0,0,0,0,0,0,0);
        // EBREAK with MIE/MPIE clear
        r(0,1,EBREAK,'h44,0,0,'h0,'h200, 1,0,0,0,0,0,0);
        r(0,0,NOP   ,'h0 ,0,0,'h0,'h200, 1,1,'h341,'h44,0,0,0);
        r(0,0,NOP   ,'h0 ,0,0,'h0,'h200, 1,1,'h342,'h3,0,0,0);
        r(0,0,NOP   ,'h0 ,0,0,'h0,'h200, 1,1,'h300,'h1800,0,0,0);
        r(0,0,NOP   ,'h0 ,0,0,'h0,'h200, 1,0,0,0,1,'h200,0);
        // vectored mtvec, k=0
        r(0,1,NOP   ,'h60,'h01,'h01,'h8,'h201, 1,0,0,0,0,0,0);
        r(0,0,NOP   ,'h0 ,'h01,'h01,'h8,'h201, 1,1,'h341,'h60,0,0,0);
        r(0,0,NOP   ,'h0 ,'h01,'h01,'h8,'h201, 1,1,'h342,'h80000010,0,0,0);
        r(0,0,NOP   ,'h0 ,'h01,'h01,'h8,'h201, 1,1,'h300,'h1880,0,0,0);
        r(0,0,NOP   ,'h0 ,'h01,'h01,'h8,'h201, 1,0,0,0,1,VEC_ADDR,'h01);
        r(0,0,NOP   ,'h0 ,'h00,'h01,'h8,'h201, 0,0,0,0,0,0,0);
        // async beats MRET; mret pc saved as mepc
        r(0,1,MRET  ,'h70,'h04,'h04,'h8,'h200, 1,0,0,0,0,0,0);
        r(0,0,NOP   ,'h0 ,'h04,'h04,'h8,'h200, 1,1,'h341,'h70,0,0,0);
        r(0,0,NOP   ,'h0 ,'h04,'h04,'h8,'h200, 1,1,'h342,'h80000012,0,0,0);
        r(0,0,NOP   ,'h0 ,'h04,'h04,'h8,'h200, 1,1,'h300,'h1880,0,0,0);
        r(0,0,NOP   ,'h0 ,'h04,'h04,'h8,'h200, 1,0,0,0,1,'h200,'h04);
        r(0,0,NOP   ,'h0 ,'h00,'h04,'h8,'h200, 0,0,0,0,0,0,0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].vld, vecs[i].inst, vecs[i].pc,
                  vecs[i].irq, vecs[i].mie, vecs[i].ms, vecs[i].mtv);
            #1;
            check($sformatf("vec%0d", i), vecs[i].hold, vecs[i].we,
                  vecs[i].wa, vecs[i].wd, vecs[i].as, vecs[i].ad,
                  vecs[i].ack);
        end

        // hand sequence: rst during MEPC aborts the whole sequence
        @(negedge clk);
        drive(0, 1, ECALL, 'h500, 0, 0, 'h8, 'h200);
        #1 check("abort_entry", 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, NOP, 0, 0, 0, 'h8, 'h200);
        #1 check("abort_rst", 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(0, 0, NOP, 0, 0, 0, 'h8, 'h200);
            #1 check($sformatf("abort_idle%0d", c), 0, 0, 0, 0, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end

endmodule
